// File: rtl/freq_sel_ctrl_pkg.sv
// Purpose: shared widths, limits, tap positions, FSM encodings and the
//          saturating target-step helper for the frequency selector controller.
package freq_sel_ctrl_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned F_W    = 15;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TAP_HI = 14;
    localparam int unsigned TAP_LO = 7;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_MIN = 3'd0;
    localparam sel_t SEL_MAX = 3'd7;

    // FSM encodings
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    // One-cycle press pulses from both button paths
    typedef struct packed {
        logic up;
        logic dn;
    } press_t;

    // Saturating step; simultaneous up+down cancels out
    function automatic sel_t sel_step(sel_t cur, press_t p);
        sel_t nxt;
        nxt = cur;
        if (p.up && !p.dn && (cur != SEL_MAX)) begin
            nxt = cur + sel_t'(1);
        end else if (p.dn && !p.up && (cur != SEL_MIN)) begin
            nxt = cur - sel_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/freq_sel_ctrl_if.sv
// Purpose: bundle of button inputs, divider bus and selector outputs.
// Signals: Btn_Up/Btn_Down raw buttons, F_in divider bus,
//          Selector/Target indices, Pending level, Forced timeout pulse.
interface freq_sel_ctrl_if;
    import freq_sel_ctrl_pkg::*;

    logic           Btn_Up;
    logic           Btn_Down;
    logic [F_W-1:0] F_in;
    sel_t           Selector;
    sel_t           Target;
    logic           Pending;
    logic           Forced;

    // Stimulus / consumer side
    modport master (
        output Btn_Up, Btn_Down, F_in,
        input  Selector, Target, Pending, Forced
    );

    // Controller side
    modport slave (
        input  Btn_Up, Btn_Down, F_in,
        output Selector, Target, Pending, Forced
    );

endinterface

// File: rtl/freq_sel_ctrl_btn_debounce.sv
// Purpose: one button path: 2-FF synchronizer, debouncer, rising-edge pulse.
// Ports: clk_i clock, rst_i async active-high reset, btn_i raw button,
//        press_o registered one-cycle pulse per accepted press.
module btn_debounce
    import freq_sel_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - CNT_W'(1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~prev_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/freq_sel_ctrl.sv
// Purpose: debounced up/down target index with glitch-safe commit to the
//          frequency mux selector, forced after a timeout.
// Ports: Clk clock, Reset async active-high reset, bus (slave modport):
//        buttons and divider bus in, Selector/Target/Pending/Forced out.
module freq_sel_ctrl
    import freq_sel_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [CNT_W-1:0] COMMIT_TIMEOUT  = 16'd4096
) (
    input  logic                 Clk,
    input  logic                 Reset,
    freq_sel_ctrl_if.slave       bus
);

    logic             up_press, dn_press;
    press_t           press_c;
    logic             safe_c;
    logic             unused_fin_lo;

    sel_t             target_q, target_d;
    sel_t             selector_q, selector_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             forced_q, forced_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .btn_i   (bus.Btn_Up),
        .press_o (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dn (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .btn_i   (bus.Btn_Down),
        .press_o (dn_press)
    );

    assign press_c       = '{up: up_press, dn: dn_press};
    // All mux candidate taps low: switching between them cannot create a runt
    assign safe_c        = (bus.F_in[TAP_HI:TAP_LO] == '0);
    assign unused_fin_lo = ^bus.F_in[TAP_LO-1:0];

    // Next state / commit decision
    always_comb begin
        target_d   = sel_step(target_q, press_c);
        state_d    = state_q;
        selector_d = selector_q;
        tmo_d      = tmo_q;
        forced_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (target_q != selector_q) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (target_q == selector_q) begin
                    // Presses undid the request: drop it without committing
                    state_d = IDLE;
                    tmo_d   = '0;
                end else if (safe_c) begin
                    selector_d = target_q;
                    state_d    = IDLE;
                    tmo_d      = '0;
                end else if (tmo_q == COMMIT_TIMEOUT - CNT_W'(1)) begin
                    selector_d = target_q;
                    forced_d   = 1'b1;
                    state_d    = IDLE;
                    tmo_d      = '0;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            target_q   <= SEL_MIN;
            selector_q <= SEL_MIN;
            state_q    <= IDLE;
            tmo_q      <= '0;
            forced_q   <= 1'b0;
        end else begin
            target_q   <= target_d;
            selector_q <= selector_d;
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            forced_q   <= forced_d;
        end
    end

    assign bus.Selector = selector_q;
    assign bus.Target   = target_q;
    assign bus.Pending  = (target_q != selector_q);
    assign bus.Forced   = forced_q;

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// Purpose: directed self-checking bench for freq_sel_ctrl with
//          DEBOUNCE_CYCLES=4 and COMMIT_TIMEOUT=32.
module tb_freq_sel_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 32;

    logic Clk = 1'b0;
    logic Reset;
    int   vec_cnt    = 0;
    int   err_cnt    = 0;
    int   forced_cnt = 0;
    bit   f_run      = 1'b0;

    freq_sel_ctrl_if bus();

    freq_sel_ctrl #(
        .DEBOUNCE_CYCLES(16'(DEB)),
        .COMMIT_TIMEOUT (16'(TMO))
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Advance one cycle; sample and update stimulus 1 time unit after the edge
    task automatic cyc();
        @(posedge Clk);
        #1;
        if (f_run) bus.F_in = bus.F_in + 15'd1;
        if (bus.Forced === 1'b1) forced_cnt++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic apply_reset();
        bus.Btn_Up   = 1'b0;
        bus.Btn_Down = 1'b0;
        Reset        = 1'b1;
        cycles(3);
        Reset        = 1'b0;
    endtask

    // Hold long enough for a press, release long enough to re-arm
    task automatic press(input bit up, input bit dn);
        bus.Btn_Up   = up;
        bus.Btn_Down = dn;
        cycles(10);
        bus.Btn_Up   = 1'b0;
        bus.Btn_Down = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset();
        #3 Reset = 1'b1;
        #1;
        vec_cnt++; if (bus.Selector !== 3'd0) begin err_cnt++; $display("FAIL rst_selector got=%0d exp=0", bus.Selector); end
        vec_cnt++; if (bus.Target !== 3'd0) begin err_cnt++; $display("FAIL rst_target got=%0d exp=0", bus.Target); end
        vec_cnt++; if (bus.Pending !== 1'b0) begin err_cnt++; $display("FAIL rst_pending got=%b exp=0", bus.Pending); end
        vec_cnt++; if (bus.Forced !== 1'b0) begin err_cnt++; $display("FAIL rst_forced got=%b exp=0", bus.Forced); end
        cycles(3);
        Reset = 1'b0;
    endtask

    // Held button: one press at cycle 2+DEB+1+1; commit after F_in wraps to 0
    task automatic test_hold_press();
        apply_reset();
        f_run      = 1'b1;
        bus.F_in   = 15'h7FF0;
        bus.Btn_Up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 7) begin
                vec_cnt++; if (bus.Target !== 3'd0) begin err_cnt++; $display("FAIL hold_tgt_c7 got=%0d exp=0", bus.Target); end
            end
            if (k == 8) begin
                vec_cnt++; if (bus.Target !== 3'd1) begin err_cnt++; $display("FAIL hold_tgt_c8 got=%0d exp=1", bus.Target); end
                vec_cnt++; if (bus.Pending !== 1'b1) begin err_cnt++; $display("FAIL hold_pend_c8 got=%b exp=1", bus.Pending); end
            end
            if (k == 16) begin
                vec_cnt++; if (bus.Selector !== 3'd0) begin err_cnt++; $display("FAIL hold_sel_c16 got=%0d exp=0", bus.Selector); end
            end
            if (k == 17) begin
                vec_cnt++; if (bus.Selector !== 3'd1) begin err_cnt++; $display("FAIL hold_sel_c17 got=%0d exp=1", bus.Selector); end
                vec_cnt++; if (bus.Pending !== 1'b0) begin err_cnt++; $display("FAIL hold_pend_c17 got=%b exp=0", bus.Pending); end
            end
        end
        bus.Btn_Up = 1'b0;
        cycles(30);
        vec_cnt++; if (bus.Target !== 3'd1) begin err_cnt++; $display("FAIL hold_single got=%0d exp=1", bus.Target); end
        vec_cnt++; if (bus.Selector !== 3'd1) begin err_cnt++; $display("FAIL hold_sel_end got=%0d exp=1", bus.Selector); end
    endtask

    // 1-0-1 bounce, 2 cycles each, then stable: level accepted on 4th stable sample
    task automatic test_bounce();
        apply_reset();
        f_run      = 1'b1;
        bus.F_in   = 15'd0;
        bus.Btn_Up = 1'b1;
        cycles(2);
        bus.Btn_Up = 1'b0;
        cycles(2);
        bus.Btn_Up = 1'b1;
        for (int k = 5; k <= 30; k++) begin
            cyc();
            if (k == 11) begin
                vec_cnt++; if (bus.Target !== 3'd0) begin err_cnt++; $display("FAIL bounce_tgt_c11 got=%0d exp=0", bus.Target); end
            end
            if (k == 12) begin
                vec_cnt++; if (bus.Target !== 3'd1) begin err_cnt++; $display("FAIL bounce_tgt_c12 got=%0d exp=1", bus.Target); end
            end
        end
        bus.Btn_Up = 1'b0;
        cycles(20);
        vec_cnt++; if (bus.Target !== 3'd1) begin err_cnt++; $display("FAIL bounce_total got=%0d exp=1", bus.Target); end
    endtask

    task automatic test_saturate();
        logic [2:0] exp_t;
        apply_reset();
        f_run    = 1'b1;
        bus.F_in = 15'd0;
        press(1'b0, 1'b1);
        vec_cnt++; if (bus.Target !== 3'd0) begin err_cnt++; $display("FAIL sat_low got=%0d exp=0", bus.Target); end
        for (int i = 1; i <= 9; i++) begin
            press(1'b1, 1'b0);
            exp_t = (i > 7) ? 3'd7 : 3'(i);
            vec_cnt++; if (bus.Target !== exp_t) begin err_cnt++; $display("FAIL sat_up%0d got=%0d exp=%0d", i, bus.Target, exp_t); end
        end
        press(1'b1, 1'b1);
        vec_cnt++; if (bus.Target !== 3'd7) begin err_cnt++; $display("FAIL sat_both got=%0d exp=7", bus.Target); end
        press(1'b0, 1'b1);
        vec_cnt++; if (bus.Target !== 3'd6) begin err_cnt++; $display("FAIL sat_down got=%0d exp=6", bus.Target); end
    endtask

    // Taps never clear: commit forced COMMIT_TIMEOUT+1 cycles after Target moves
    task automatic test_timeout();
        int n;
        apply_reset();
        f_run    = 1'b0;
        bus.F_in = 15'd0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        vec_cnt++; if (bus.Selector !== 3'd2) begin err_cnt++; $display("FAIL tmo_pre_sel got=%0d exp=2", bus.Selector); end
        bus.F_in   = 15'h7F80;
        forced_cnt = 0;
        bus.Btn_Up = 1'b1;
        n = 0;
        while (bus.Target !== 3'd3 && n < 20) begin
            cyc();
            n++;
        end
        vec_cnt++; if (bus.Target !== 3'd3) begin err_cnt++; $display("FAIL tmo_tgt got=%0d exp=3", bus.Target); end
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.Selector === 3'd2 && n < 60);
        vec_cnt++; if (n != TMO + 1) begin err_cnt++; $display("FAIL tmo_latency got=%0d exp=%0d", n, TMO + 1); end
        vec_cnt++; if (bus.Selector !== 3'd3) begin err_cnt++; $display("FAIL tmo_sel got=%0d exp=3", bus.Selector); end
        vec_cnt++; if (bus.Forced !== 1'b1) begin err_cnt++; $display("FAIL tmo_forced got=%b exp=1", bus.Forced); end
        cyc();
        vec_cnt++; if (bus.Forced !== 1'b0) begin err_cnt++; $display("FAIL tmo_forced_off got=%b exp=0", bus.Forced); end
        vec_cnt++; if (bus.Pending !== 1'b0) begin err_cnt++; $display("FAIL tmo_pending got=%b exp=0", bus.Pending); end
        vec_cnt++; if (forced_cnt != 1) begin err_cnt++; $display("FAIL tmo_pulses got=%0d exp=1", forced_cnt); end
        bus.Btn_Up = 1'b0;
        cycles(10);
    endtask

    // Up then Down while pending: request withdrawn, nothing committed or forced
    task automatic test_cancel();
        apply_reset();
        f_run      = 1'b0;
        bus.F_in   = 15'h7F80;
        forced_cnt = 0;
        press(1'b1, 1'b0);
        vec_cnt++; if (bus.Target !== 3'd1) begin err_cnt++; $display("FAIL cancel_tgt1 got=%0d exp=1", bus.Target); end
        vec_cnt++; if (bus.Pending !== 1'b1) begin err_cnt++; $display("FAIL cancel_pend1 got=%b exp=1", bus.Pending); end
        press(1'b0, 1'b1);
        vec_cnt++; if (bus.Target !== 3'd0) begin err_cnt++; $display("FAIL cancel_tgt0 got=%0d exp=0", bus.Target); end
        vec_cnt++; if (bus.Pending !== 1'b0) begin err_cnt++; $display("FAIL cancel_pend0 got=%b exp=0", bus.Pending); end
        cycles(50);
        vec_cnt++; if (bus.Selector !== 3'd0) begin err_cnt++; $display("FAIL cancel_sel got=%0d exp=0", bus.Selector); end
        vec_cnt++; if (forced_cnt != 0) begin err_cnt++; $display("FAIL cancel_forced got=%0d exp=0", forced_cnt); end
    endtask

    // Async reset while Target=5 pending over Selector=4
    task automatic test_reset_pending();
        apply_reset();
        f_run    = 1'b0;
        bus.F_in = 15'd0;
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        vec_cnt++; if (bus.Selector !== 3'd4) begin err_cnt++; $display("FAIL rstp_sel4 got=%0d exp=4", bus.Selector); end
        bus.F_in = 15'h7F80;
        press(1'b1, 1'b0);
        vec_cnt++; if (bus.Target !== 3'd5) begin err_cnt++; $display("FAIL rstp_tgt5 got=%0d exp=5", bus.Target); end
        vec_cnt++; if (bus.Pending !== 1'b1) begin err_cnt++; $display("FAIL rstp_pend got=%b exp=1", bus.Pending); end
        Reset = 1'b1;
        #2;
        vec_cnt++; if (bus.Selector !== 3'd0) begin err_cnt++; $display("FAIL rstp_async_sel got=%0d exp=0", bus.Selector); end
        vec_cnt++; if (bus.Target !== 3'd0) begin err_cnt++; $display("FAIL rstp_async_tgt got=%0d exp=0", bus.Target); end
        vec_cnt++; if (bus.Pending !== 1'b0) begin err_cnt++; $display("FAIL rstp_async_pend got=%b exp=0", bus.Pending); end
        cycles(2);
        Reset      = 1'b0;
        forced_cnt = 0;
        cycles(50);
        vec_cnt++; if (bus.Selector !== 3'd0) begin err_cnt++; $display("FAIL rstp_post_sel got=%0d exp=0", bus.Selector); end
        vec_cnt++; if (bus.Target !== 3'd0) begin err_cnt++; $display("FAIL rstp_post_tgt got=%0d exp=0", bus.Target); end
        vec_cnt++; if (forced_cnt != 0) begin err_cnt++; $display("FAIL rstp_post_forced got=%0d exp=0", forced_cnt); end
    endtask

    initial begin
        Reset        = 1'b0;
        bus.Btn_Up   = 1'b0;
        bus.Btn_Down = 1'b0;
        bus.F_in     = 15'd0;
        test_reset();
        test_hold_press();
        test_bounce();
        test_saturate();
        test_timeout();
        test_cancel();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
